// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - frame format, FSM encoding and baud divisor helper shared by the UART
package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;

  // Integer-truncated clocks per bit; the receiver uses the same rounding.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int frame_bits(input int parity_en, input int stop_bits);
    return START_BITS + DATA_BITS + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered count/full/empty and no read bypass
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_NFUL = (AW + 1)'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // A simultaneous push and pop leaves occupancy untouched.
      case ({push, pop})
        2'b10: begin
          count <= count + CNT_ONE;
          full  <= (count == CNT_NFUL);
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - CNT_ONE;
          full  <= 1'b0;
          empty <= (count == CNT_ONE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter: FIFO feeding an 8-bit LSB-first serialiser
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       transmit,
  input  logic [7:0] data_tx,
  output logic       full,
  output logic       empty,
  output logic       busy_tx,
  output logic       overflow,
  output logic       tx
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
  localparam logic [2:0]    BIT_LAST   = 3'(DATA_BITS - 1);
  localparam logic          ODD_BIT    = (PARITY_ODD != 0);
  localparam logic          HAS_PARITY = (PARITY_EN != 0);
  localparam logic          STOP_LAST  = (STOP_BITS == 2);

  tx_state_e     state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          parity_bit, parity_n;
  logic          stop_cnt, stop_n;
  logic          tx_n;
  logic          tick;
  logic          pop;
  logic [7:0]    fifo_data;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (transmit),
    .wr_data (data_tx),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (empty)
  );

  assign tick    = (baud_cnt == BAUD_LAST);
  assign busy_tx = (state != ST_IDLE) | ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      stop_cnt   <= 1'b0;
      tx         <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_idx    <= bit_n;
      shift      <= shift_n;
      parity_bit <= parity_n;
      stop_cnt   <= stop_n;
      tx         <= tx_n;
      if (transmit && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    baud_n   = tick ? '0 : baud_cnt + BAUD_ONE;
    bit_n    = bit_idx;
    shift_n  = shift;
    parity_n = parity_bit;
    stop_n   = stop_cnt;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          state_n = ST_DATA;
          bit_n   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == BIT_LAST) begin
            state_n = HAS_PARITY ? ST_PARITY : ST_STOP;
            stop_n  = 1'b0;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_n = ST_STOP;
          stop_n  = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            // Chain straight into the next start bit so queued bytes leave without a gap.
            if (!empty) begin
              pop     = 1'b1;
              state_n = ST_START;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            stop_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (pop) begin
      shift_n  = fifo_data;
      parity_n = (^fifo_data) ^ ODD_BIT;
    end

    tx_n = 1'b1;
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
      ST_PARITY: tx_n = parity_n;
      default:   tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       tr_a, tr_p, tr_o, tr_d;
  logic [7:0] d_a, d_p, d_o, d_d;
  logic       full_a, empty_a, busy_a, ovf_a, tx_a;
  logic       full_p, empty_p, busy_p, ovf_p, tx_p;
  logic       full_o, empty_o, busy_o, ovf_o, tx_o;
  logic       full_d, empty_d, busy_d, ovf_d, tx_d;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.CLK_HZ(800), .BAUD(100)) u_a (
    .clk(clk), .rst(rst), .transmit(tr_a), .data_tx(d_a), .full(full_a),
    .empty(empty_a), .busy_tx(busy_a), .overflow(ovf_a), .tx(tx_a));

  uart_tx_fifo #(.CLK_HZ(800), .BAUD(100), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_p (
    .clk(clk), .rst(rst), .transmit(tr_p), .data_tx(d_p), .full(full_p),
    .empty(empty_p), .busy_tx(busy_p), .overflow(ovf_p), .tx(tx_p));

  uart_tx_fifo #(.CLK_HZ(800), .BAUD(100), .PARITY_EN(1), .PARITY_ODD(1)) u_o (
    .clk(clk), .rst(rst), .transmit(tr_o), .data_tx(d_o), .full(full_o),
    .empty(empty_o), .busy_tx(busy_o), .overflow(ovf_o), .tx(tx_o));

  uart_tx_fifo u_d (
    .clk(clk), .rst(rst), .transmit(tr_d), .data_tx(d_d), .full(full_d),
    .empty(empty_d), .busy_tx(busy_d), .overflow(ovf_d), .tx(tx_d));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_tx(input int w);
    case (w)
      0:       return tx_a;
      1:       return tx_p;
      2:       return tx_o;
      default: return tx_d;
    endcase
  endfunction

  task automatic drive(input int w, input logic t, input logic [7:0] d);
    case (w)
      0:       begin tr_a = t; d_a = d; end
      1:       begin tr_p = t; d_p = d; end
      2:       begin tr_o = t; d_o = d; end
      default: begin tr_d = t; d_d = d; end
    endcase
  endtask

  task automatic wait_start(input int w, input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (get_tx(w) == 1'b0) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  // Starts on the first cycle of a start bit; records each bit's first sample and counts in-bit changes.
  task automatic capture(input int w, input int div, input int nbits,
                         output logic [11:0] bits, output int bad);
    logic v;
    bits = '0;
    bad  = 0;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < div; c++) begin
        v = get_tx(w);
        if (c == 0) bits[i] = v;
        else if (v !== bits[i]) bad++;
        step();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) step();
    checks++;
    if ({tx_a, empty_a, busy_a, full_a, ovf_a} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_held: got %b expected 11000", {tx_a, empty_a, busy_a, full_a, ovf_a});
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if ({tx_a, empty_a, busy_a, full_a, ovf_a} !== 5'b11000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %b expected 11000", i,
                 {tx_a, empty_a, busy_a, full_a, ovf_a});
      end
    end
  endtask

  task automatic test_single_frame();
    logic [11:0] bits;
    int          bad;
    drive(0, 1'b1, 8'hA5);
    step();
    drive(0, 1'b0, 8'h00);
    checks++;
    if (tx_a !== 1'b1 || empty_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL a5_after_push: tx=%b empty=%b busy=%b expected 1 0 1", tx_a, empty_a, busy_a);
    end
    step();
    checks++;
    if (tx_a !== 1'b0) begin
      errors++;
      $display("FAIL a5_start_latency: tx=%b expected 0", tx_a);
    end
    capture(0, 8, 10, bits, bad);
    checks++;
    if (bits[9:0] !== {1'b1, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL a5_bits: got %b expected %b", bits[9:0], {1'b1, 8'hA5, 1'b0});
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL a5_width: %0d in-bit changes, expected 0", bad);
    end
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL a5_end: tx=%b busy=%b expected 1 0", tx_a, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] bits;
    int          bad;
    logic        ok;
    int          lows;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          drive(0, 1'b1, 8'(i));
          step();
          if (i == 5) begin
            checks++;
            if (full_a !== 1'b1) begin
              errors++;
              $display("FAIL b2b_full: full=%b expected 1", full_a);
            end
          end
        end
        drive(0, 1'b0, 8'h00);
        checks++;
        if (ovf_a !== 1'b1) begin
          errors++;
          $display("FAIL b2b_overflow_set: overflow=%b expected 1", ovf_a);
        end
      end
      begin
        wait_start(0, 20, ok);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL b2b_start_timeout: no start bit within 20 cycles");
        end
        for (int k = 0; k < 5; k++) begin
          capture(0, 8, 10, bits, bad);
          checks++;
          if (bits[9:0] !== {1'b1, 8'(k + 1), 1'b0} || bad !== 0) begin
            errors++;
            $display("FAIL b2b_frame%0d: got %b bad=%0d expected %b", k, bits[9:0], bad,
                     {1'b1, 8'(k + 1), 1'b0});
          end
        end
      end
    join
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || empty_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: tx=%b busy=%b empty=%b expected 1 0 1", tx_a, busy_a, empty_a);
    end
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_a !== 1'b1) lows++;
      step();
    end
    checks++;
    if (lows !== 0 || ovf_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_dropped: low cycles=%0d overflow=%b expected 0 1", lows, ovf_a);
    end
  endtask

  task automatic test_parity();
    logic [11:0] bits;
    int          bad;
    logic        ok;
    drive(1, 1'b1, 8'h07);
    step();
    drive(1, 1'b0, 8'h00);
    wait_start(1, 5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL even_start_timeout: no start bit");
    end
    capture(1, 8, 12, bits, bad);
    checks++;
    if (bits !== {2'b11, 1'b1, 8'h07, 1'b0} || bad !== 0) begin
      errors++;
      $display("FAIL even_frame: got %b bad=%0d expected %b", bits, bad, {2'b11, 1'b1, 8'h07, 1'b0});
    end
    checks++;
    if (tx_p !== 1'b1 || busy_p !== 1'b0) begin
      errors++;
      $display("FAIL even_stop_len: tx=%b busy=%b expected 1 0", tx_p, busy_p);
    end
    drive(2, 1'b1, 8'h07);
    step();
    drive(2, 1'b0, 8'h00);
    wait_start(2, 5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL odd_start_timeout: no start bit");
    end
    capture(2, 8, 11, bits, bad);
    checks++;
    if (bits[10:0] !== {1'b1, 1'b0, 8'h07, 1'b0} || bad !== 0) begin
      errors++;
      $display("FAIL odd_frame: got %b bad=%0d expected %b", bits[10:0], bad, {1'b1, 1'b0, 8'h07, 1'b0});
    end
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL odd_end: tx=%b busy=%b expected 1 0", tx_o, busy_o);
    end
  endtask

  task automatic test_reset_midframe();
    int lows;
    drive(0, 1'b1, 8'h11);
    step();
    drive(0, 1'b1, 8'h22);
    step();
    drive(0, 1'b1, 8'h33);
    step();
    drive(0, 1'b0, 8'h00);
    // Now on cycle 1 of the start bit; cycle 35 lies inside d3 (a 0 for 0x11).
    repeat (34) step();
    checks++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1 || empty_a !== 1'b0) begin
      errors++;
      $display("FAIL midframe_pre: tx=%b busy=%b empty=%b expected 0 1 0", tx_a, busy_a, empty_a);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({tx_a, empty_a, busy_a, full_a, ovf_a} !== 5'b11000) begin
      errors++;
      $display("FAIL midframe_reset: got %b expected 11000", {tx_a, empty_a, busy_a, full_a, ovf_a});
    end
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx_a !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL midframe_quiet: %0d low cycles expected 0", lows);
    end
  endtask

  task automatic test_default_baud();
    logic [11:0] bits;
    int          bad;
    drive(3, 1'b1, 8'h55);
    step();
    drive(3, 1'b0, 8'h00);
    step();
    checks++;
    if (tx_d !== 1'b0) begin
      errors++;
      $display("FAIL def_start_latency: tx=%b expected 0", tx_d);
    end
    capture(3, 434, 10, bits, bad);
    checks++;
    if (bits[9:0] !== {1'b1, 8'h55, 1'b0} || bad !== 0) begin
      errors++;
      $display("FAIL def_frame: got %b bad=%0d expected %b", bits[9:0], bad, {1'b1, 8'h55, 1'b0});
    end
    checks++;
    if (tx_d !== 1'b1 || busy_d !== 1'b0) begin
      errors++;
      $display("FAIL def_len_4340: tx=%b busy=%b expected 1 0", tx_d, busy_d);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    drive(3, 1'b0, 8'h00);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity();
    test_reset_midframe();
    test_default_baud();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
